// File: rtl/irq_pkg.sv
// Shared definitions for the vectored interrupt controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, default source count, vector-width helper.
package irq_pkg;

  // Default number of interrupt sources.
  localparam int IRQ_NUM_SRC_DEFAULT = 8;

  // Request/acknowledge FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

  // Vector width: max(1, clog2(n)).
  function automatic int irq_vec_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: lowest-index active bit wins.
// Latency: purely combinational.
// Backpressure: none.
// Ports: active (request vector) -> win_idx (winner index), any_active (|active).
module irq_priority_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = IRQ_NUM_SRC_DEFAULT,
  parameter int VEC_W   = irq_vec_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] active,
  output logic [VEC_W-1:0]   win_idx,
  output logic               any_active
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        win_idx = VEC_W'(i);
      end
    end
  end

  assign any_active = |active;

endmodule

// File: rtl/vectored_irq_ctrl.sv
// Vectored interrupt controller: per-source edge/level latching, mask, fixed priority, REQ/ack/EOI handshake.
// Latency: pending sets on the edge an input edge/level is sampled; int_o rises one cycle later.
// Backpressure: one request outstanding; int_o held until int_ack_i or source drop, no nesting while in service.
// Ports: clk_i/rst_i; int_src, int_mode, int_mask, int_clear, int_ack_i in;
//        pending, in_service, int_vector, int_o out.
module vectored_irq_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_SRC = IRQ_NUM_SRC_DEFAULT,
  parameter int VEC_W   = irq_vec_width(NUM_SRC)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] int_src,
  input  logic [NUM_SRC-1:0] int_mode,
  input  logic [NUM_SRC-1:0] int_mask,
  input  logic [NUM_SRC-1:0] int_clear,
  input  logic               int_ack_i,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] in_service,
  output logic [VEC_W-1:0]   int_vector,
  output logic               int_o
);

  irq_state_t         state;
  irq_state_t         state_nxt;
  logic               vec_load;

  logic [NUM_SRC-1:0] src_q;
  logic               primed;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] pending_nxt;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] vec_onehot;
  logic [VEC_W-1:0]   win_idx;
  logic               any_active;
  logic               sel_active;
  logic               sel_clear;

  // ---------------------------------------------------------------------------
  // Edge detection. src_q clears in reset, so the first cycle out of reset has
  // no valid history; 'primed' suppresses edges until src_q holds a real sample.
  // That way a source already high at reset release is not taken as an edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q  <= '0;
      primed <= 1'b0;
    end else begin
      src_q  <= int_src;
      primed <= 1'b1;
    end
  end

  assign edge_det = primed ? (int_src & ~src_q) : '0;

  // Edge mode: set beats clear. Level mode: registered copy of the input.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int_mode[i]) begin
        if (edge_det[i]) begin
          pending_nxt[i] = 1'b1;
        end else if (int_clear[i]) begin
          pending_nxt[i] = 1'b0;
        end
      end else begin
        pending_nxt[i] = int_src[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  assign active = pending & int_mask;

  irq_priority_enc #(
    .NUM_SRC (NUM_SRC),
    .VEC_W   (VEC_W)
  ) u_prio (
    .active     (active),
    .win_idx    (win_idx),
    .any_active (any_active)
  );

  // One-hot of the latched vector; used to pick the latched source's active
  // and clear bits without indexing past NUM_SRC.
  always_comb begin
    vec_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      vec_onehot[i] = (int_vector == VEC_W'(i));
    end
  end

  assign sel_active = |(active & vec_onehot);
  assign sel_clear  = |(int_clear & vec_onehot);

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An ack arriving on the same cycle the source drops still goes to SERVICE:
  // the CPU has committed to the vector it read.
  always_comb begin
    state_nxt = state;
    vec_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_active) begin
          state_nxt = ST_REQ;
          vec_load  = 1'b1;
        end
      end
      ST_REQ: begin
        if (int_ack_i) begin
          state_nxt = ST_SERVICE;
        end else if (!sel_active) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        // EOI is taken from the strobe for both modes; a level source's
        // pending bit ignores it but the handshake still completes.
        if (sel_clear) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Vector is frozen from IDLE->REQ through the end of SERVICE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      int_vector <= '0;
    end else if (vec_load) begin
      int_vector <= win_idx;
    end
  end

  // Decoded from registered state so a reset drops them immediately.
  assign int_o      = (state == ST_REQ);
  assign in_service = (state == ST_SERVICE) ? vec_onehot : '0;

endmodule

// File: tb/tb_vectored_irq_ctrl.sv
// Self-checking bench for vectored_irq_ctrl: directed scenarios followed by random traffic,
// compared every cycle against a behavioural model of the pending/request rules.
// Clock period 10; inputs change 1 after the rising edge, outputs sampled 1 after it.
module tb_vectored_irq_ctrl;
  import irq_pkg::*;

  localparam int N = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [N-1:0] int_src;
  logic [N-1:0] int_mode;
  logic [N-1:0] int_mask;
  logic [N-1:0] int_clear;
  logic         int_ack_i;
  logic [N-1:0] pending;
  logic [N-1:0] in_service;
  logic [2:0]   int_vector;
  logic         int_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: pending bits, last sampled sources, whether that sample is valid,
  // handshake phase (0 idle, 1 requesting, 2 in service) and the latched vector.
  logic [N-1:0] m_pend;
  logic [N-1:0] m_prev;
  bit           m_hist;
  int           m_phase;
  int           m_vec;

  vectored_irq_ctrl #(.NUM_SRC(N), .VEC_W(3)) u_dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .int_src    (int_src),
    .int_mode   (int_mode),
    .int_mask   (int_mask),
    .int_clear  (int_clear),
    .int_ack_i  (int_ack_i),
    .pending    (pending),
    .in_service (in_service),
    .int_vector (int_vector),
    .int_o      (int_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs present before it.
  task automatic model_step();
    logic [N-1:0] np;
    int win;
    if (rst_i) begin
      m_pend = '0; m_prev = '0; m_hist = 0; m_phase = 0; m_vec = 0;
      return;
    end
    win = -1;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i] && int_mask[i]) win = i;
    for (int i = 0; i < N; i++) begin
      if (int_mode[i]) begin
        if (m_hist && int_src[i] && !m_prev[i]) np[i] = 1'b1;
        else if (int_clear[i])                  np[i] = 1'b0;
        else                                    np[i] = m_pend[i];
      end else begin
        np[i] = int_src[i];
      end
    end
    if (m_phase == 0) begin
      if (win >= 0) begin m_phase = 1; m_vec = win; end
    end else if (m_phase == 1) begin
      if (int_ack_i) m_phase = 2;
      else if (!(m_pend[m_vec] && int_mask[m_vec])) m_phase = 0;
    end else begin
      if (int_clear[m_vec]) m_phase = 0;
    end
    m_pend = np;
    m_prev = int_src;
    m_hist = 1;
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] exp_is;
    exp_is = (m_phase == 2) ? N'(1 << m_vec) : '0;
    check({tag, ".pending"},    32'(pending),    32'(m_pend));
    check({tag, ".in_service"}, 32'(in_service), 32'(exp_is));
    check({tag, ".int_vector"}, 32'(int_vector), 32'(m_vec));
    check({tag, ".int_o"},      32'(int_o),      32'(m_phase == 1));
  endtask

  task automatic tick(input string tag);
    @(posedge clk_i);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_i = 1'b1; int_src = '0; int_mode = 8'hFF; int_mask = 8'hFF;
    int_clear = '0; int_ack_i = 1'b0;
    model_step();

    // Reset with sources toggling: outputs stay zero, FSM idle.
    for (int k = 0; k < 4; k++) begin
      int_src = $urandom; int_ack_i = 1'b1;
      tick("rst");
    end
    check("rst_state", 32'(u_dut.state), 32'(ST_IDLE));
    check("rst_int_o", 32'(int_o), 32'h0);
    int_src = '0; int_ack_i = 1'b0;
    tick("rst_last");
    rst_i = 1'b0;
    tick("post_rst");

    // Single edge source 3 through the full handshake.
    int_src = 8'h08;
    tick("e3_set");
    check("e3_pending", 32'(pending), 32'h08);
    check("e3_no_req_yet", 32'(int_o), 32'h0);
    int_src = '0;
    tick("e3_req");
    check("e3_int_o", 32'(int_o), 32'h1);
    check("e3_vec", 32'(int_vector), 32'h3);
    int_ack_i = 1'b1;
    tick("e3_ack");
    int_ack_i = 1'b0;
    check("e3_ack_int_o", 32'(int_o), 32'h0);
    check("e3_in_service", 32'(in_service), 32'h08);
    tick("e3_svc_hold");
    int_clear = 8'h08;
    tick("e3_eoi");
    int_clear = '0;
    check("e3_eoi_pending", 32'(pending), 32'h0);
    check("e3_eoi_is", 32'(in_service), 32'h0);
    tick("e3_idle");
    check("e3_idle_int_o", 32'(int_o), 32'h0);

    // Simultaneous edges on 2 and 5: 2 first, then 5 after its EOI.
    int_src = 8'h24;
    tick("e25_set");
    int_src = '0;
    tick("e25_req");
    check("e25_vec2", 32'(int_vector), 32'h2);
    int_ack_i = 1'b1;
    tick("e25_ack");
    int_ack_i = 1'b0;
    int_clear = 8'h04;
    tick("e25_eoi2");
    int_clear = '0;
    check("e25_pend5", 32'(pending), 32'h20);
    tick("e25_rereq");
    check("e25_int_o", 32'(int_o), 32'h1);
    check("e25_vec5", 32'(int_vector), 32'h5);
    int_ack_i = 1'b1;
    tick("e25_ack5");
    int_ack_i = 1'b0;
    int_clear = 8'h20;
    tick("e25_eoi5");
    int_clear = '0;

    // Masked pending, unmask, then edge colliding with clear.
    int_mask = 8'h00; int_src = 8'h01;
    tick("m0_set");
    int_src = '0;
    check("m0_pending", 32'(pending), 32'h01);
    tick("m0_masked");
    check("m0_masked_int_o", 32'(int_o), 32'h0);
    int_mask = 8'h01;
    tick("m0_unmask");
    check("m0_unmask_int_o", 32'(int_o), 32'h1);
    int_src = 8'h01; int_clear = 8'h01;
    tick("m0_collide");
    int_src = '0; int_clear = '0;
    check("m0_set_wins", 32'(pending), 32'h01);
    int_ack_i = 1'b1;
    tick("m0_ack");
    int_ack_i = 1'b0;
    int_clear = 8'h01;
    tick("m0_eoi");
    int_clear = '0;
    int_mask = 8'hFF;

    // Level source 1: clear strobe ignored, release withdraws the request.
    int_mode = 8'hFD; int_src = 8'h02;
    tick("l1_set");
    tick("l1_req");
    check("l1_vec", 32'(int_vector), 32'h1);
    int_clear = 8'h02;
    tick("l1_clr");
    int_clear = '0;
    check("l1_clr_pending", 32'(pending), 32'h02);
    check("l1_clr_int_o", 32'(int_o), 32'h1);
    int_src = '0;
    tick("l1_drop");
    check("l1_drop_pending", 32'(pending), 32'h0);
    tick("l1_idle");
    check("l1_idle_int_o", 32'(int_o), 32'h0);

    // Reset mid-service on edge source 4, source held high across release.
    int_mode = 8'hFF; int_src = 8'h10;
    tick("r4_set");
    tick("r4_req");
    int_ack_i = 1'b1;
    tick("r4_ack");
    int_ack_i = 1'b0;
    check("r4_is", 32'(in_service), 32'h10);
    #2 rst_i = 1'b1;
    #1;
    model_step();
    check("r4_async_is", 32'(in_service), 32'h0);
    check("r4_async_int_o", 32'(int_o), 32'h0);
    check_all("r4_async");
    tick("r4_in_rst");
    rst_i = 1'b0;
    for (int k = 0; k < 3; k++) tick("r4_held");
    check("r4_no_pending", 32'(pending), 32'h0);
    check("r4_no_req", 32'(int_o), 32'h0);
    int_src = '0;
    tick("r4_low");
    int_src = 8'h10;
    tick("r4_rearm");
    check("r4_rearm_pending", 32'(pending), 32'h10);

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      if (c % 200 == 0) begin
        int_mode = N'($urandom);
        int_mask = N'($urandom);
      end
      if ($urandom_range(0, 15) == 0) int_mask = N'($urandom);
      if ($urandom_range(0, 2) == 0) int_src = int_src ^ N'(1 << $urandom_range(0, N - 1));
      int_ack_i = ($urandom_range(0, 3) == 0);
      int_clear = '0;
      if ($urandom_range(0, 3) == 0) int_clear = N'(1 << $urandom_range(0, N - 1));
      if (m_phase == 2 && $urandom_range(0, 2) == 0) int_clear = int_clear | N'(1 << m_vec);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
